mem_access_ctrl: RTL and testbench

//  MEM-stage load/store engine; consumes ram_en / ram_write_en / ram_read_flag produced by I-type decode.

---
 rtl/mem_access_ctrl_pkg.sv | 34 +++
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_data_align.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store engine: FSM codes, access sizes,
// reset constants and the alignment rule.
package mem_access_ctrl_pkg;

  typedef logic [1:0] mem_state_t;
  typedef logic [1:0] mem_size_t;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_DONE = 2'd2;
  localparam logic [1:0] MEM_ERR  = 2'd3;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  localparam int MEM_TIMEOUT = 256;

  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG_ADDR  = 5'd0;
  localparam logic        WRITE_ENABLE   = 1'b1;
  localparam logic        WRITE_DISABLE  = 1'b0;

  // The reserved size code 2'b11 is never aligned, so it is reported as misaligned.
  function automatic logic access_aligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_BYTE: return 1'b1;
      MEM_SIZE_HALF: return ~addr_lo[0];
      MEM_SIZE_WORD: return (addr_lo == 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge memory bus between the MEM-stage engine (master) and memory (slave).
interface mem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_data_align.sv
// Combinational little-endian lane logic: lane enables and replicated store data,
// plus lane extraction and zero/sign extension of load data.
module mem_data_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata_raw,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  sel,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    sel        = 4'b0000;
    wdata_lane = wdata_raw;
    rdata_ext  = rdata_raw;
    byte_v     = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_v     = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (size)
      MEM_SIZE_BYTE: begin
        sel        = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata_raw[7:0]}};
        rdata_ext  = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      MEM_SIZE_HALF: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_raw[15:0]}};
        rdata_ext  = {{16{sign_ext & half_v[15]}}, half_v};
      end
      MEM_SIZE_WORD: begin
        sel = 4'b1111;
      end
      default: begin
        sel = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store engine: one req/ack bus transaction per access, pipeline stall
// while it is outstanding, and a registered write-back result for WB.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ram_en,
  input  logic               ram_write_en,
  input  logic               ram_read_flag,
  input  logic [1:0]         mem_size,
  input  logic               mem_signed,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [31:0]        alu_result,
  input  logic               write_reg_en,
  input  logic [4:0]         write_reg_addr,
  mem_access_ctrl_if.master  bus,
  output logic               stall_req,
  output logic               misalign,
  output logic               bus_err,
  output logic               wb_write_reg_en,
  output logic [4:0]         wb_write_reg_addr,
  output logic [31:0]        wb_data
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       addr_lo_p1;
  logic [1:0]       size_p1;
  logic             signed_p1;
  logic [31:0]      rdata_p1;

  logic        aligned;
  logic [1:0]  align_size;
  logic [1:0]  align_lo;
  logic        align_sign;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [31:0] load_data;

  assign aligned   = access_aligned(mem_size, mem_addr[1:0]);
  assign stall_req = ((state == MEM_IDLE) && ram_en && aligned) ||
                     (state == MEM_REQ) || (state == MEM_ERR);

  // Issue uses the live request; after issue the captured copy drives load extraction.
  assign align_size = (state == MEM_IDLE) ? mem_size      : size_p1;
  assign align_lo   = (state == MEM_IDLE) ? mem_addr[1:0] : addr_lo_p1;
  assign align_sign = (state == MEM_IDLE) ? mem_signed    : signed_p1;

  mem_data_align u_align (
    .size       (align_size),
    .addr_lo    (align_lo),
    .sign_ext   (align_sign),
    .wdata_raw  (mem_wdata),
    .rdata_raw  (rdata_p1),
    .sel        (sel_c),
    .wdata_lane (wdata_c),
    .rdata_ext  (load_data)
  );

  // Bus transaction FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= MEM_IDLE;
      cnt           <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= ZERO_WORD;
      bus.bus_sel   <= 4'b0000;
      bus.bus_wdata <= ZERO_WORD;
      addr_lo_p1    <= 2'b00;
      size_p1       <= MEM_SIZE_BYTE;
      signed_p1     <= 1'b0;
      rdata_p1      <= ZERO_WORD;
      misalign      <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (ram_en && aligned) begin
            state         <= MEM_REQ;
            cnt           <= '0;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= ram_write_en;
            bus.bus_addr  <= {mem_addr[31:2], 2'b00};
            bus.bus_sel   <= sel_c;
            bus.bus_wdata <= wdata_c;
            addr_lo_p1    <= mem_addr[1:0];
            size_p1       <= mem_size;
            signed_p1     <= mem_signed;
          end else if (ram_en) begin
            misalign <= 1'b1;
          end
        end
        MEM_REQ: begin
          if (bus.bus_ack) begin
            state       <= MEM_DONE;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            rdata_p1    <= bus.bus_rdata;
          end else if (cnt == CNT_LAST) begin
            state       <= MEM_ERR;
            bus.bus_req <= 1'b0;
            bus.bus_we  <= 1'b0;
            bus_err     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEM_DONE: state <= MEM_IDLE;
        MEM_ERR:  state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

  // Write-back register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_write_reg_en   <= WRITE_DISABLE;
      wb_write_reg_addr <= ZERO_REG_ADDR;
      wb_data           <= ZERO_WORD;
    end else if (state == MEM_ERR) begin
      wb_write_reg_en <= WRITE_DISABLE;
    end else if (!stall_req) begin
      wb_write_reg_addr <= write_reg_addr;
      if (state == MEM_DONE) begin
        wb_write_reg_en <= ram_read_flag;
        wb_data         <= load_data;
      end else if (ram_en) begin
        // Only a misaligned access reaches here unstalled: it must not write back.
        wb_write_reg_en <= WRITE_DISABLE;
        wb_data         <= alu_result;
      end else begin
        wb_write_reg_en <= write_reg_en;
        wb_data         <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, misalignment, timeout and reset abort.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ram_en, ram_write_en, ram_read_flag, mem_signed, write_reg_en;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, alu_result;
  logic [4:0]  write_reg_addr;
  logic        stall_req, misalign, bus_err, wb_write_reg_en;
  logic [4:0]  wb_write_reg_addr;
  logic [31:0] wb_data;

  int passed = 0;
  int total  = 0;

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(256), .CNT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .ram_en            (ram_en),
    .ram_write_en      (ram_write_en),
    .ram_read_flag     (ram_read_flag),
    .mem_size          (mem_size),
    .mem_signed        (mem_signed),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .alu_result        (alu_result),
    .write_reg_en      (write_reg_en),
    .write_reg_addr    (write_reg_addr),
    .bus               (bus_if),
    .stall_req         (stall_req),
    .misalign          (misalign),
    .bus_err           (bus_err),
    .wb_write_reg_en   (wb_write_reg_en),
    .wb_write_reg_addr (wb_write_reg_addr),
    .wb_data           (wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ram_en = 0; ram_write_en = 0; ram_read_flag = 0; mem_size = 2'b00; mem_signed = 0;
    mem_addr = 0; mem_wdata = 0; alu_result = 0; write_reg_en = 0; write_reg_addr = 0;
  endtask

  task automatic set_access(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    ram_en = 1; ram_write_en = we; ram_read_flag = ~we; mem_size = size; mem_signed = sgn;
    mem_addr = addr; mem_wdata = wd; alu_result = 32'h1111_1111; write_reg_en = ~we;
    write_reg_addr = rd;
  endtask

  // Acts as the memory: acks in the ack_at-th REQ cycle. Returns at the negedge of DONE.
  task automatic do_access(input int ack_at, input logic [31:0] rdata,
                           output int stall_cnt, output int req_cnt, output int rise_cnt,
                           output logic [3:0] sel, output logic we, output logic [31:0] addr,
                           output logic [31:0] wdata, output bit held, output bit timed_out);
    logic prev_req = 1'b0;
    stall_cnt = 0; req_cnt = 0; rise_cnt = 0; held = 1; timed_out = 1;
    sel = 0; we = 0; addr = 0; wdata = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus_if.bus_req && !prev_req) rise_cnt++;
      prev_req = bus_if.bus_req;
      if (bus_if.bus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          sel = bus_if.bus_sel; we = bus_if.bus_we; addr = bus_if.bus_addr; wdata = bus_if.bus_wdata;
        end else if (bus_if.bus_sel !== sel || bus_if.bus_we !== we ||
                     bus_if.bus_addr !== addr || bus_if.bus_wdata !== wdata) begin
          held = 0;
        end
      end
      if (stall_req) stall_cnt++;
      else if (c > 0) begin
        timed_out = 0;
        bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
        break;
      end
      bus_if.bus_ack   = bus_if.bus_req && (req_cnt == ack_at);
      bus_if.bus_rdata = bus_if.bus_ack ? rdata : 32'h0;
    end
    bus_if.bus_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    total++; if (bus_if.bus_req !== 1'b0) $display("FAIL reset_bus_req got=%b exp=0", bus_if.bus_req); else passed++;
    total++; if (bus_if.bus_we !== 1'b0) $display("FAIL reset_bus_we got=%b exp=0", bus_if.bus_we); else passed++;
    total++; if (bus_if.bus_sel !== 4'h0) $display("FAIL reset_bus_sel got=%h exp=0", bus_if.bus_sel); else passed++;
    total++; if (stall_req !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_req); else passed++;
    total++; if ({misalign, bus_err} !== 2'b00) $display("FAIL reset_pulses got=%b exp=00", {misalign, bus_err}); else passed++;
    total++; if ({wb_write_reg_en, wb_write_reg_addr, wb_data} !== 38'h0)
      $display("FAIL reset_wb got=%b/%h/%h exp=0/00/00000000", wb_write_reg_en, wb_write_reg_addr, wb_data); else passed++;
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_word_load();
    int sc, rc, rr; logic [3:0] s; logic w; logic [31:0] a, d; bit h, to;
    @(posedge clk); #1 set_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
    do_access(3, 32'hDEAD_BEEF, sc, rc, rr, s, w, a, d, h, to);
    total++; if (to) $display("FAIL wl_done got=timeout exp=DONE reached"); else passed++;
    total++; if (sc != 4) $display("FAIL wl_stall_cycles got=%0d exp=4", sc); else passed++;
    total++; if (rc != 3 || rr != 1) $display("FAIL wl_req got=%0d cycles/%0d rises exp=3/1", rc, rr); else passed++;
    total++; if (s !== 4'b1111 || w !== 1'b0 || a !== 32'h100)
      $display("FAIL wl_bus got=sel %b we %b addr %h exp=1111 0 00000100", s, w, a); else passed++;
    total++; if (!h) $display("FAIL wl_bus_held got=changed exp=constant"); else passed++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    total++; if (wb_write_reg_en !== 1'b1 || wb_write_reg_addr !== 5'd5)
      $display("FAIL wl_wb_en got=%b/%0d exp=1/5", wb_write_reg_en, wb_write_reg_addr); else passed++;
    total++; if (wb_data !== 32'hDEAD_BEEF) $display("FAIL wl_wb_data got=%h exp=deadbeef", wb_data); else passed++;
  endtask

  task automatic test_byte_load();
    int sc, rc, rr; logic [3:0] s; logic w; logic [31:0] a, d; bit h, to;
    logic [31:0] exp_data [2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 set_access(1'b0, 2'b00, (k == 0), 32'h103, 32'h0, 5'd3);
      do_access(1, 32'h80FF_FFFF, sc, rc, rr, s, w, a, d, h, to);
      total++; if (to || sc != 2) $display("FAIL bl_stall[%0d] got=%0d timeout=%0b exp=2", k, sc, to); else passed++;
      total++; if (s !== 4'b1000 || a !== 32'h100) $display("FAIL bl_bus[%0d] got=sel %b addr %h exp=1000 00000100", k, s, a); else passed++;
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      total++; if (wb_data !== exp_data[k] || wb_write_reg_en !== 1'b1)
        $display("FAIL bl_wb[%0d] got=%b/%h exp=1/%h", k, wb_write_reg_en, wb_data, exp_data[k]); else passed++;
    end
  endtask

  task automatic test_half_store();
    int sc, rc, rr; logic [3:0] s; logic w; logic [31:0] a, d; bit h, to;
    @(posedge clk); #1 set_access(1'b1, 2'b01, 1'b0, 32'h202, 32'hABCD_1234, 5'd0);
    do_access(1, 32'h0, sc, rc, rr, s, w, a, d, h, to);
    total++; if (to || sc != 2) $display("FAIL hs_stall got=%0d timeout=%0b exp=2", sc, to); else passed++;
    total++; if (w !== 1'b1 || s !== 4'b1100) $display("FAIL hs_we_sel got=%b/%b exp=1/1100", w, s); else passed++;
    total++; if (d !== 32'h1234_1234 || a !== 32'h200) $display("FAIL hs_wdata got=%h@%h exp=12341234@00000200", d, a); else passed++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    total++; if (wb_write_reg_en !== 1'b0) $display("FAIL hs_wb_en got=%b exp=0", wb_write_reg_en); else passed++;
  endtask

  task automatic test_misalign();
    @(posedge clk); #1 idle_inputs(); write_reg_en = 1; write_reg_addr = 5'd9; alu_result = 32'h55;
    @(posedge clk); #1 set_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd4);
    @(negedge clk);
    total++; if (stall_req !== 1'b0 || bus_if.bus_req !== 1'b0)
      $display("FAIL ma_no_stall got=stall %b req %b exp=0 0", stall_req, bus_if.bus_req); else passed++;
    total++; if (wb_write_reg_en !== 1'b1 || wb_write_reg_addr !== 5'd9 || wb_data !== 32'h55)
      $display("FAIL ma_nonmem_wb got=%b/%0d/%h exp=1/9/00000055", wb_write_reg_en, wb_write_reg_addr, wb_data); else passed++;
    @(posedge clk); #1 idle_inputs(); write_reg_en = 1; write_reg_addr = 5'd7; alu_result = 32'hCAFE;
    @(negedge clk);
    total++; if (misalign !== 1'b1 || wb_write_reg_en !== 1'b0 || bus_if.bus_req !== 1'b0)
      $display("FAIL ma_pulse got=mis %b wb_en %b req %b exp=1 0 0", misalign, wb_write_reg_en, bus_if.bus_req); else passed++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    total++; if (misalign !== 1'b0) $display("FAIL ma_pulse_end got=%b exp=0", misalign); else passed++;
    total++; if (wb_write_reg_en !== 1'b1 || wb_data !== 32'hCAFE)
      $display("FAIL ma_next_wb got=%b/%h exp=1/0000cafe", wb_write_reg_en, wb_data); else passed++;
    @(posedge clk); #1 set_access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd4);
    @(negedge clk);
    total++; if (stall_req !== 1'b0) $display("FAIL ma_rsv_stall got=%b exp=0", stall_req); else passed++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    total++; if (misalign !== 1'b1 || bus_if.bus_req !== 1'b0)
      $display("FAIL ma_rsv_pulse got=mis %b req %b exp=1 0", misalign, bus_if.bus_req); else passed++;
  endtask

  task automatic test_timeout();
    int rc = 0; bit seen = 0;
    @(posedge clk); #1 idle_inputs(); write_reg_en = 1; write_reg_addr = 5'd2; alu_result = 32'h9;
    @(posedge clk); #1 set_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd6);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus_err) begin seen = 1; break; end
      if (bus_if.bus_req) rc++;
    end
    total++; if (!seen || rc != 256) $display("FAIL to_req_cycles got=%0d seen=%0b exp=256 1", rc, seen); else passed++;
    total++; if (bus_if.bus_req !== 1'b0 || stall_req !== 1'b1)
      $display("FAIL to_err_state got=req %b stall %b exp=0 1", bus_if.bus_req, stall_req); else passed++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    total++; if (bus_err !== 1'b0 || stall_req !== 1'b0)
      $display("FAIL to_idle got=err %b stall %b exp=0 0", bus_err, stall_req); else passed++;
    total++; if (wb_write_reg_en !== 1'b0) $display("FAIL to_wb_en got=%b exp=0", wb_write_reg_en); else passed++;
  endtask

  task automatic test_back_to_back();
    int sc, rc, rr; logic [3:0] s; logic w; logic [31:0] a, d; bit h, to;
    @(posedge clk); #1 idle_inputs(); write_reg_en = 1; write_reg_addr = 5'd8; alu_result = 32'h77;
    @(posedge clk); #1 set_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd6);
    repeat (3) @(negedge clk);
    total++; if (bus_if.bus_req !== 1'b1) $display("FAIL rr_req_before got=%b exp=1", bus_if.bus_req); else passed++;
    #2 rst = 0; idle_inputs();
    #1;
    total++; if (bus_if.bus_req !== 1'b0 || bus_if.bus_sel !== 4'h0 || bus_if.bus_addr !== 32'h0)
      $display("FAIL rr_bus_zero got=%b/%h/%h exp=0/0/00000000", bus_if.bus_req, bus_if.bus_sel, bus_if.bus_addr); else passed++;
    total++; if (stall_req !== 1'b0 || wb_write_reg_en !== 1'b0 || wb_data !== 32'h0)
      $display("FAIL rr_out_zero got=stall %b wb %b/%h exp=0 0/00000000", stall_req, wb_write_reg_en, wb_data); else passed++;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    total++; if (bus_if.bus_req !== 1'b0 || stall_req !== 1'b0)
      $display("FAIL rr_idle got=req %b stall %b exp=0 0", bus_if.bus_req, stall_req); else passed++;
    @(posedge clk); #1 set_access(1'b1, 2'b10, 1'b0, 32'h500, 32'hA5A5_5A5A, 5'd0);
    do_access(1, 32'h0, sc, rc, rr, s, w, a, d, h, to);
    total++; if (to || sc != 2 || rr != 1) $display("FAIL b2b_st got=stall %0d rises %0d to %0b exp=2 1 0", sc, rr, to); else passed++;
    total++; if (w !== 1'b1 || s !== 4'hF || d !== 32'hA5A5_5A5A || a !== 32'h500)
      $display("FAIL b2b_st_bus got=%b/%b/%h/%h exp=1/1111/a5a55a5a/00000500", w, s, d, a); else passed++;
    @(posedge clk); #1 set_access(1'b0, 2'b00, 1'b0, 32'h501, 32'h0, 5'd12);
    total++; if (wb_write_reg_en !== 1'b0) $display("FAIL b2b_st_wb got=%b exp=0", wb_write_reg_en); else passed++;
    do_access(1, 32'h0000_C300, sc, rc, rr, s, w, a, d, h, to);
    total++; if (to || sc != 2 || rr != 1) $display("FAIL b2b_ld got=stall %0d rises %0d to %0b exp=2 1 0", sc, rr, to); else passed++;
    total++; if (s !== 4'b0010 || w !== 1'b0) $display("FAIL b2b_ld_bus got=%b/%b exp=0010/0", s, w); else passed++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    total++; if (wb_write_reg_en !== 1'b1 || wb_write_reg_addr !== 5'd12 || wb_data !== 32'h0000_00C3)
      $display("FAIL b2b_ld_wb got=%b/%0d/%h exp=1/12/000000c3", wb_write_reg_en, wb_write_reg_addr, wb_data); else passed++;
    total++; if (bus_if.bus_req !== 1'b0) $display("FAIL b2b_no_dup got=%b exp=0", bus_if.bus_req); else passed++;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
